// File: rtl/bsg_decode.sv
// Binary-to-one-hot decoder: output bit i is set, all others clear.
// Latency: purely combinational.
// Backpressure: none; no flow control of its own.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_decode #(
  parameter  int num_out_p     = 8,
  localparam int lg_num_out_lp = `BSG_SAFE_CLOG2(num_out_p)
) (
  input  logic [lg_num_out_lp-1:0] i,
  output logic [num_out_p-1:0]     o
);

  assign o = num_out_p'(1) << i;

endmodule

// File: rtl/bsg_arb_rr_decode.sv
// Registered round-robin arbiter: binary tag plus one-hot grant for one shared sink.
// Latency: one cycle from request to grant; no combinational reqs_i -> output path.
// Backpressure: the grant holds until yumi_i, which re-arbitrates on the same edge.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_arb_rr_decode #(
  parameter  int els_p     = 8,
  localparam int lg_els_lp = `BSG_SAFE_CLOG2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [els_p-1:0]     reqs_i,
  output logic                 v_o,
  output logic [lg_els_lp-1:0] tag_o,
  output logic [els_p-1:0]     grants_o,
  input  logic                 yumi_i
);

  logic                 v_r, v_n;
  logic [lg_els_lp-1:0] tag_r, tag_n;
  logic [lg_els_lp-1:0] last_r, last_n;
  logic [lg_els_lp-1:0] ptr, start, win;
  logic [2*els_p-1:0]   dbl;
  logic                 found, load, consume;
  logic [els_p-1:0]     dec;

  assign consume = v_r & yumi_i;
  assign load    = ~v_r | yumi_i;

  always_comb begin
    // On a consume edge the tag being retired is the new pointer.
    ptr   = consume ? tag_r : last_r;
    start = (ptr == lg_els_lp'(els_p - 1)) ? '0 : ptr + lg_els_lp'(1);
    dbl   = {reqs_i, reqs_i};
    found = 1'b0;
    win   = '0;
    // Bits below start are masked; the upper copy supplies the wrap-around.
    for (int k = 0; k < 2 * els_p; k++) begin
      if (!found && dbl[k] && (k >= int'(start))) begin
        found = 1'b1;
        win   = lg_els_lp'(k % els_p);
      end
    end
  end

  always_comb begin
    v_n    = v_r;
    tag_n  = tag_r;
    last_n = last_r;
    if (consume) last_n = tag_r;
    if (load) begin
      v_n = found;
      if (found) tag_n = win;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_r    <= 1'b0;
      tag_r  <= '0;
      last_r <= lg_els_lp'(els_p - 1);
    end else begin
      v_r    <= v_n;
      tag_r  <= tag_n;
      last_r <= last_n;
    end
  end

  bsg_decode #(.num_out_p(els_p)) dec_inst (
    .i (tag_r),
    .o (dec)
  );

  assign v_o      = v_r;
  assign tag_o    = tag_r;
  assign grants_o = v_r ? dec : '0;

  // A yumi with nothing presented is a sink protocol error.
  assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_r));

endmodule

// File: tb/tb_bsg_arb_rr_decode.sv
// Bench for bsg_arb_rr_decode at els_p = 4 (directed), 1 and 128 (random with a reference model).
// Latency: expectations are queued at drive time and popped one clock later.
// Backpressure: yumi is only driven while the model says a grant is presented.
module tb_bsg_arb_rr_decode;

  logic clk = 1'b0;
  logic reset_i;

  logic [3:0]   reqs4;   logic yumi4;   logic v4;   logic [1:0] tag4;   logic [3:0]   grants4;
  logic [0:0]   reqs1;   logic yumi1;   logic v1;   logic [0:0] tag1;   logic [0:0]   grants1;
  logic [127:0] reqs128; logic yumi128; logic v128; logic [6:0] tag128; logic [127:0] grants128;

  always #5 clk = ~clk;

  bsg_arb_rr_decode #(.els_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .reqs_i(reqs4), .v_o(v4),
    .tag_o(tag4), .grants_o(grants4), .yumi_i(yumi4));

  bsg_arb_rr_decode #(.els_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .reqs_i(reqs1), .v_o(v1),
    .tag_o(tag1), .grants_o(grants1), .yumi_i(yumi1));

  bsg_arb_rr_decode #(.els_p(128)) dut128 (
    .clk_i(clk), .reset_i(reset_i), .reqs_i(reqs128), .v_o(v128),
    .tag_o(tag128), .grants_o(grants128), .yumi_i(yumi128));

  typedef struct { logic v; int tag; logic ng; } exp_t;
  typedef struct { logic [3:0] r; logic y; logic v; int tag; } row_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q128[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference scan: walk offsets 1..n from the pointer, first request wins.
  function automatic void ref_arb(input int n, input logic [127:0] r, input int ptr,
                                  output logic f, output int w);
    int idx;
    f = 1'b0;
    w = 0;
    for (int j = 1; j <= n; j++) begin
      idx = (ptr + j) % n;
      if (!f && r[idx]) begin
        f = 1'b1;
        w = idx;
      end
    end
  endfunction

  task automatic drv4(input logic [3:0] r, input logic y, input logic ev, input int et);
    exp_t e;
    reqs4 = r;
    yumi4 = y;
    e.v   = ev;
    e.tag = et;
    e.ng  = 1'b0;
    q4.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    reset_i = 1'b1;
    reqs4 = 4'b1111; yumi4 = 1'b0;
    reqs1 = '0;      yumi1 = 1'b0;
    reqs128 = '0;    yumi128 = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (v4 !== 1'b0)       $display("FAIL reset v_o got %b want 0", v4); else n_pass++;
    n_chk++; if (grants4 !== 4'b0)  $display("FAIL reset grants_o got %b want 0000", grants4); else n_pass++;
    n_chk++; if (tag4 !== 2'd0)     $display("FAIL reset tag_o got %0d want 0", tag4); else n_pass++;
    n_chk++; if (v1 !== 1'b0)       $display("FAIL reset els1 v_o got %b want 0", v1); else n_pass++;
    n_chk++; if (v128 !== 1'b0)     $display("FAIL reset els128 v_o got %b want 0", v128); else n_pass++;
    reset_i = 1'b0;
    drv4(4'b1111, 1'b0, 1'b1, 0);
    e = q4.pop_front();
    n_chk++; if (v4 !== e.v)           $display("FAIL reset_release v_o got %b want %b", v4, e.v); else n_pass++;
    n_chk++; if (tag4 !== 2'(e.tag))   $display("FAIL reset_release tag_o got %0d want %0d", tag4, e.tag); else n_pass++;
    n_chk++; if (grants4 !== 4'b0001)  $display("FAIL reset_release grants_o got %b want 0001", grants4); else n_pass++;
  endtask

  task automatic test_rotation();
    row_t rows[4];
    exp_t e;
    rows[0] = '{4'b1111, 1'b1, 1'b1, 1};
    rows[1] = '{4'b1111, 1'b1, 1'b1, 2};
    rows[2] = '{4'b1111, 1'b1, 1'b1, 3};
    rows[3] = '{4'b1111, 1'b1, 1'b1, 0};
    foreach (rows[i]) begin
      drv4(rows[i].r, rows[i].y, rows[i].v, rows[i].tag);
      e = q4.pop_front();
      n_chk++; if (v4 !== e.v) $display("FAIL rotation[%0d] v_o got %b want %b", i, v4, e.v); else n_pass++;
      n_chk++; if (tag4 !== 2'(e.tag)) $display("FAIL rotation[%0d] tag_o got %0d want %0d", i, tag4, e.tag); else n_pass++;
      n_chk++; if (grants4 !== (4'(1) << e.tag)) $display("FAIL rotation[%0d] grants_o got %b want tag %0d", i, grants4, e.tag); else n_pass++;
    end
  endtask

  task automatic test_hold();
    row_t rows[7];
    exp_t e;
    rows[0] = '{4'b0100, 1'b1, 1'b1, 2};
    rows[1] = '{4'b0001, 1'b0, 1'b1, 2};
    rows[2] = '{4'b0000, 1'b0, 1'b1, 2};
    rows[3] = '{4'b0001, 1'b0, 1'b1, 2};
    rows[4] = '{4'b1011, 1'b0, 1'b1, 2};
    rows[5] = '{4'b0001, 1'b0, 1'b1, 2};
    rows[6] = '{4'b0001, 1'b1, 1'b1, 0};
    foreach (rows[i]) begin
      drv4(rows[i].r, rows[i].y, rows[i].v, rows[i].tag);
      e = q4.pop_front();
      n_chk++; if (v4 !== e.v) $display("FAIL hold[%0d] v_o got %b want %b", i, v4, e.v); else n_pass++;
      n_chk++; if (tag4 !== 2'(e.tag)) $display("FAIL hold[%0d] tag_o got %0d want %0d", i, tag4, e.tag); else n_pass++;
      n_chk++; if (grants4 !== (4'(1) << e.tag)) $display("FAIL hold[%0d] grants_o got %b want tag %0d", i, grants4, e.tag); else n_pass++;
    end
  endtask

  task automatic test_wrap_skip();
    row_t rows[4];
    exp_t e;
    rows[0] = '{4'b1000, 1'b1, 1'b1, 3};
    rows[1] = '{4'b0100, 1'b1, 1'b1, 2};
    rows[2] = '{4'b1001, 1'b1, 1'b1, 3};
    rows[3] = '{4'b1001, 1'b1, 1'b1, 0};
    foreach (rows[i]) begin
      drv4(rows[i].r, rows[i].y, rows[i].v, rows[i].tag);
      e = q4.pop_front();
      n_chk++; if (v4 !== e.v) $display("FAIL wrap[%0d] v_o got %b want %b", i, v4, e.v); else n_pass++;
      n_chk++; if (tag4 !== 2'(e.tag)) $display("FAIL wrap[%0d] tag_o got %0d want %0d", i, tag4, e.tag); else n_pass++;
      n_chk++; if (grants4 !== (4'(1) << e.tag)) $display("FAIL wrap[%0d] grants_o got %b want tag %0d", i, grants4, e.tag); else n_pass++;
    end
  endtask

  task automatic test_empty();
    row_t rows[4];
    exp_t e;
    rows[0] = '{4'b0000, 1'b1, 1'b0, 0};
    rows[1] = '{4'b0010, 1'b0, 1'b1, 1};
    rows[2] = '{4'b0000, 1'b0, 1'b1, 1};
    rows[3] = '{4'b1000, 1'b1, 1'b1, 3};
    foreach (rows[i]) begin
      drv4(rows[i].r, rows[i].y, rows[i].v, rows[i].tag);
      e = q4.pop_front();
      n_chk++; if (v4 !== e.v) $display("FAIL empty[%0d] v_o got %b want %b", i, v4, e.v); else n_pass++;
      if (e.v) begin
        n_chk++; if (tag4 !== 2'(e.tag)) $display("FAIL empty[%0d] tag_o got %0d want %0d", i, tag4, e.tag); else n_pass++;
      end
      n_chk++; if (grants4 !== (e.v ? (4'(1) << e.tag) : 4'b0)) $display("FAIL empty[%0d] grants_o got %b", i, grants4); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    // Grant tag 3 is presented and the pointer sits at 1.
    #1 reset_i = 1'b1; yumi4 = 1'b0;
    #1;
    n_chk++; if (v4 !== 1'b0)      $display("FAIL async_reset1 v_o got %b want 0", v4); else n_pass++;
    n_chk++; if (grants4 !== 4'b0) $display("FAIL async_reset1 grants_o got %b want 0000", grants4); else n_pass++;
    @(negedge clk);
    reset_i = 1'b0;
    // With the pointer back at 3, index 1 beats index 3.
    drv4(4'b1010, 1'b0, 1'b1, 1);
    e = q4.pop_front();
    n_chk++; if (tag4 !== 2'(e.tag)) $display("FAIL ptr_reset tag_o got %0d want %0d", tag4, e.tag); else n_pass++;
    drv4(4'b1000, 1'b1, 1'b1, 3);
    e = q4.pop_front();
    n_chk++; if (tag4 !== 2'(e.tag)) $display("FAIL pre_reset2 tag_o got %0d want %0d", tag4, e.tag); else n_pass++;
    #1 reset_i = 1'b1; yumi4 = 1'b0;
    #1;
    n_chk++; if (v4 !== 1'b0) $display("FAIL async_reset2 v_o got %b want 0", v4); else n_pass++;
    @(negedge clk);
    reset_i = 1'b0;
    drv4(4'b1000, 1'b0, 1'b1, 3);
    e = q4.pop_front();
    n_chk++; if (v4 !== e.v)         $display("FAIL after_reset v_o got %b want %b", v4, e.v); else n_pass++;
    n_chk++; if (tag4 !== 2'(e.tag)) $display("FAIL after_reset tag_o got %0d want %0d", tag4, e.tag); else n_pass++;
    n_chk++; if (grants4 !== 4'b1000) $display("FAIL after_reset grants_o got %b want 1000", grants4); else n_pass++;
    drv4(4'b0000, 1'b1, 1'b0, 0);
    e = q4.pop_front();
    n_chk++; if (v4 !== e.v) $display("FAIL drain v_o got %b want %b", v4, e.v); else n_pass++;
  endtask

  task automatic test_rand_els1();
    exp_t e;
    logic mv = 1'b0;
    logic y;
    logic [0:0] r;
    for (int c = 0; c < 300; c++) begin
      r = 1'($urandom_range(0, 1));
      y = mv ? 1'($urandom_range(0, 1)) : 1'b0;
      reqs1 = r;
      yumi1 = y;
      if (!mv || y) mv = r[0];
      e.v = mv; e.tag = 0; e.ng = 1'b0;
      q1.push_back(e);
      @(negedge clk);
      e = q1.pop_front();
      n_chk++; if (v1 !== e.v) $display("FAIL els1[%0d] v_o got %b want %b", c, v1, e.v); else n_pass++;
      n_chk++; if (tag1 !== 1'b0) $display("FAIL els1[%0d] tag_o got %0d want 0", c, tag1); else n_pass++;
      n_chk++; if (grants1 !== e.v) $display("FAIL els1[%0d] grants_o got %b want %b", c, grants1, e.v); else n_pass++;
    end
    yumi1 = 1'b0;
    reqs1 = '0;
  endtask

  task automatic test_rand_els128();
    exp_t e;
    logic mv = 1'b0;
    int mtag = 0;
    int mlast = 127;
    int ptr, w;
    logic f, y;
    logic [127:0] r;
    int held[3];
    int cnt[3];
    int maxw[3];
    held[0] = 0; held[1] = 64; held[2] = 127;
    foreach (cnt[k]) begin cnt[k] = 0; maxw[k] = 0; end
    for (int c = 0; c < 400; c++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      if (c >= 20) begin
        r[0] = 1'b1; r[64] = 1'b1; r[127] = 1'b1;
      end
      y = mv ? ($urandom_range(0, 3) != 0) : 1'b0;
      reqs128 = r;
      yumi128 = y;
      ptr = (mv && y) ? mtag : mlast;
      if (mv && y) mlast = mtag;
      e.ng = 1'b0;
      if (!mv || y) begin
        ref_arb(128, r, ptr, f, w);
        mv = f;
        if (f) begin mtag = w; e.ng = (c >= 20); end
      end
      e.v = mv; e.tag = mtag;
      q128.push_back(e);
      @(negedge clk);
      e = q128.pop_front();
      n_chk++; if (v128 !== e.v) $display("FAIL els128[%0d] v_o got %b want %b", c, v128, e.v); else n_pass++;
      if (e.v) begin
        n_chk++; if (tag128 !== 7'(e.tag)) $display("FAIL els128[%0d] tag_o got %0d want %0d", c, tag128, e.tag); else n_pass++;
      end
      n_chk++; if (grants128 !== (e.v ? (128'(1) << e.tag) : 128'(0))) $display("FAIL els128[%0d] grants_o not one-hot of tag %0d", c, e.tag); else n_pass++;
      if (e.ng) begin
        foreach (held[k]) begin
          if (int'(tag128) == held[k]) cnt[k] = 0;
          else cnt[k]++;
          if (cnt[k] > maxw[k]) maxw[k] = cnt[k];
        end
      end
    end
    foreach (held[k]) begin
      n_chk++;
      if (maxw[k] > 127) $display("FAIL starve req %0d waited %0d grants, bound 127", held[k], maxw[k]);
      else n_pass++;
    end
    if (mv) begin
      reqs128 = '0;
      yumi128 = 1'b1;
      @(negedge clk);
    end
    yumi128 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_hold();
    test_wrap_skip();
    test_empty();
    test_async_reset();
    reqs4 = 4'b0000;
    yumi4 = 1'b0;
    test_rand_els1();
    test_rand_els128();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
